// File: rtl/uart_param.sv
// Parametrised full-duplex UART with receive status (valid, parity, framing, false-start). tx leaves idle on the edge that samples start.
// rx_valid follows the stop-bit centre; there is no backpressure, and start is ignored while tx_active. Optional loopback: UART_PARAM_LOOPBACK_EN.
module uart_param #(
  parameter int clk_freq    = 50000000,
  parameter int baud_rate   = 19200,
  parameter int data_bits   = 8,
  parameter int parity_type = 0,
  parameter int stop_bits   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [data_bits-1:0] tx_data_in,
  input  logic                 start,
`ifdef UART_PARAM_LOOPBACK_EN
  input  logic                 loopback,
`endif
  output logic                 tx,
  output logic                 tx_active,
  output logic                 done_tx,
  output logic [data_bits-1:0] rx_data_out,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);
  localparam int CLKS_PER_BIT = clk_freq / baud_rate;
  localparam int STOP_CLKS    = stop_bits * CLKS_PER_BIT;
  localparam int CW           = $clog2(STOP_CLKS + 1);
  localparam int BW           = $clog2(data_bits + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CLKS - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(data_bits - 1);
  localparam bit PAR_EN = (parity_type != 0);

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT} rx_state_t;

  function automatic logic par_of(input logic [data_bits-1:0] d);
    return (^d) ^ (parity_type == 1);
  endfunction

  // Reset asserts immediately but is released in step with clk.
  logic [1:0] rst_pipe;
  logic       rst_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_pipe <= 2'b11;
    else     rst_pipe <= {rst_pipe[0], 1'b0};
  end
  assign rst_i = rst_pipe[1];

  tx_state_t            tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [data_bits-1:0] tx_shift;
  logic                 tx_par, tx_line;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      tx_state  <= T_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      tx_par    <= 1'b0;
      tx_line   <= 1'b1;
      tx_active <= 1'b0;
      done_tx   <= 1'b0;
    end else begin
      done_tx <= 1'b0;
      case (tx_state)
        T_IDLE: if (start) begin
          tx_shift  <= tx_data_in;
          tx_par    <= par_of(tx_data_in);
          tx_line   <= 1'b0;
          tx_active <= 1'b1;
          tx_cnt    <= '0;
          tx_bit    <= '0;
          tx_state  <= T_START;
        end
        T_START: if (tx_cnt == BIT_LAST) begin
          tx_cnt   <= '0;
          tx_line  <= tx_shift[0];
          tx_shift <= tx_shift >> 1;
          tx_state <= T_DATA;
        end else tx_cnt <= tx_cnt + 1'b1;
        T_DATA: if (tx_cnt == BIT_LAST) begin
          tx_cnt <= '0;
          if (tx_bit == IDX_LAST) begin
            tx_bit   <= '0;
            tx_line  <= PAR_EN ? tx_par : 1'b1;
            tx_state <= PAR_EN ? T_PAR : T_STOP;
          end else begin
            tx_bit   <= tx_bit + 1'b1;
            tx_line  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end
        end else tx_cnt <= tx_cnt + 1'b1;
        T_PAR: if (tx_cnt == BIT_LAST) begin
          tx_cnt   <= '0;
          tx_line  <= 1'b1;
          tx_state <= T_STOP;
        end else tx_cnt <= tx_cnt + 1'b1;
        T_STOP: if (tx_cnt == STOP_LAST) begin
          tx_cnt    <= '0;
          tx_active <= 1'b0;
          done_tx   <= 1'b1;
          tx_state  <= T_IDLE;
        end else tx_cnt <= tx_cnt + 1'b1;
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  logic [1:0] rx_sync;
  logic       rx_src;
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) rx_sync <= 2'b11;
    else       rx_sync <= {rx_sync[0], rx};
  end

`ifdef UART_PARAM_LOOPBACK_EN
  assign tx     = loopback ? 1'b1 : tx_line;
  assign rx_src = loopback ? tx_line : rx_sync[1];
`else
  assign tx     = tx_line;
  assign rx_src = rx_sync[1];
`endif

  rx_state_t            rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [data_bits-1:0] rx_shift;
  logic                 rx_par, rx_prev;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      rx_state      <= R_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_par        <= 1'b0;
      rx_prev       <= 1'b1;
      rx_data_out   <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_prev  <= rx_src;
      case (rx_state)
        R_IDLE: if (rx_prev && !rx_src) begin
          rx_cnt   <= '0;
          rx_busy  <= 1'b1;
          rx_state <= R_START;
        end
        R_START: if (rx_cnt == HALF_LAST) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          if (rx_src) begin
            rx_busy  <= 1'b0;
            rx_state <= R_IDLE;
          end else rx_state <= R_DATA;
        end else rx_cnt <= rx_cnt + 1'b1;
        R_DATA: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_src, rx_shift[data_bits-1:1]};
          if (rx_bit == IDX_LAST) begin
            rx_bit   <= '0;
            rx_state <= PAR_EN ? R_PAR : R_STOP;
          end else rx_bit <= rx_bit + 1'b1;
        end else rx_cnt <= rx_cnt + 1'b1;
        R_PAR: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_par   <= rx_src;
          rx_state <= R_STOP;
        end else rx_cnt <= rx_cnt + 1'b1;
        // A low stop sample parks in R_WAIT so a held break reports once.
        R_STOP: if (rx_cnt == BIT_LAST) begin
          rx_cnt        <= '0;
          rx_data_out   <= rx_shift;
          rx_valid      <= 1'b1;
          rx_parity_err <= PAR_EN && (rx_par != par_of(rx_shift));
          rx_frame_err  <= !rx_src;
          if (rx_src) begin
            rx_busy  <= 1'b0;
            rx_state <= R_IDLE;
          end else rx_state <= R_WAIT;
        end else rx_cnt <= rx_cnt + 1'b1;
        R_WAIT: if (rx_src) begin
          rx_busy  <= 1'b0;
          rx_state <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: 8N1, 8E1 and 7O2 instances at 10 clocks per bit, checked against a frame-level line model.
module tb_uart_param;
  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [8:0] txd = '0;
  logic [2:0] start_v = '0;
`ifdef UART_PARAM_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif
  logic [2:0] tx_v, act_v, dtx_v, rxv_v, perr_v, ferr_v, busy_v;
  logic [7:0] rxd0, rxd1;
  logic [6:0] rxd2;

  int checks = 0;
  int errors = 0;
  int nb_c [3] = '{8, 8, 7};
  int pt_c [3] = '{0, 2, 1};
  int ns_c [3] = '{1, 1, 2};

  always #5 clk = ~clk;

  uart_param #(.clk_freq(1000000), .baud_rate(100000), .data_bits(8), .parity_type(0), .stop_bits(1)) u_8n1 (
    .clk(clk), .rst(rst), .rx(rx), .tx_data_in(txd[7:0]), .start(start_v[0]),
`ifdef UART_PARAM_LOOPBACK_EN
    .loopback(loopback),
`endif
    .tx(tx_v[0]), .tx_active(act_v[0]), .done_tx(dtx_v[0]), .rx_data_out(rxd0), .rx_valid(rxv_v[0]),
    .rx_parity_err(perr_v[0]), .rx_frame_err(ferr_v[0]), .rx_busy(busy_v[0]));

  uart_param #(.clk_freq(1000000), .baud_rate(100000), .data_bits(8), .parity_type(2), .stop_bits(1)) u_8e1 (
    .clk(clk), .rst(rst), .rx(rx), .tx_data_in(txd[7:0]), .start(start_v[1]),
`ifdef UART_PARAM_LOOPBACK_EN
    .loopback(loopback),
`endif
    .tx(tx_v[1]), .tx_active(act_v[1]), .done_tx(dtx_v[1]), .rx_data_out(rxd1), .rx_valid(rxv_v[1]),
    .rx_parity_err(perr_v[1]), .rx_frame_err(ferr_v[1]), .rx_busy(busy_v[1]));

  uart_param #(.clk_freq(1000000), .baud_rate(100000), .data_bits(7), .parity_type(1), .stop_bits(2)) u_7o2 (
    .clk(clk), .rst(rst), .rx(rx), .tx_data_in(txd[6:0]), .start(start_v[2]),
`ifdef UART_PARAM_LOOPBACK_EN
    .loopback(loopback),
`endif
    .tx(tx_v[2]), .tx_active(act_v[2]), .done_tx(dtx_v[2]), .rx_data_out(rxd2), .rx_valid(rxv_v[2]),
    .rx_parity_err(perr_v[2]), .rx_frame_err(ferr_v[2]), .rx_busy(busy_v[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] rxd_sel(input int s);
    case (s)
      0:       return {1'b0, rxd0};
      1:       return {1'b0, rxd1};
      default: return {2'b00, rxd2};
    endcase
  endfunction

  function automatic int flen(input int s);
    return 1 + nb_c[s] + ((pt_c[s] != 0) ? 1 : 0) + ns_c[s];
  endfunction

  // Line level of every bit of a frame: start, data LSB first, optional parity, stop bits.
  function automatic logic [15:0] frame_of(input int s, input logic [8:0] d);
    logic [15:0] f;
    int ones;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < nb_c[s]; i++) begin
      f[1 + i] = d[i];
      if (d[i]) ones++;
    end
    if (pt_c[s] == 1) f[1 + nb_c[s]] = (ones % 2 == 0);
    if (pt_c[s] == 2) f[1 + nb_c[s]] = (ones % 2 == 1);
    return f;
  endfunction

  // Called at a negedge; returns at the negedge where done_tx should be visible.
  task automatic tx_frame(input int s, input logic [8:0] d, input bit keep);
    logic [15:0] f;
    int len, bad, act_lo, dpulse;
    f = frame_of(s, d);
    len = flen(s);
    bad = 0; act_lo = 0; dpulse = 0;
    txd = d;
    start_v[s] = 1'b1;
    for (int c = 0; c < len * CPB; c++) begin
      @(negedge clk);
      if (!keep) start_v[s] = 1'b0;
      if (tx_v[s] !== f[c / CPB]) bad++;
      if (act_v[s] !== 1'b1) act_lo++;
      if (dtx_v[s] !== 1'b0) dpulse++;
      txd = 9'($urandom);
    end
    chk("tx_bits", 32'(bad), 32'(0));
    chk("tx_active_hold", 32'(act_lo), 32'(0));
    chk("done_tx_early", 32'(dpulse), 32'(0));
    @(negedge clk);
    chk("done_tx_pulse", 32'(dtx_v[s]), 32'(1));
    chk("tx_active_end", 32'(act_v[s]), 32'(0));
    chk("tx_line_idle", 32'(tx_v[s]), 32'(1));
  endtask

  task automatic rx_frame(input int s, input logic [8:0] d, input bit flip, input bit stop_val);
    logic [15:0] f;
    int len, pulses;
    logic [8:0] got;
    logic pe, fe, exp_pe;
    f = frame_of(s, d);
    len = flen(s);
    if (flip && pt_c[s] != 0) f[1 + nb_c[s]] = ~f[1 + nb_c[s]];
    f[len - ns_c[s]] = stop_val;
    exp_pe = flip && (pt_c[s] != 0);
    pulses = 0; got = '0; pe = 1'b0; fe = 1'b0;
    for (int c = 0; c < (len + 2) * CPB; c++) begin
      rx = (c < len * CPB) ? f[c / CPB] : 1'b1;
      @(negedge clk);
      if (rxv_v[s] === 1'b1) begin
        pulses++;
        got = rxd_sel(s);
        pe = perr_v[s];
        fe = ferr_v[s];
      end
    end
    chk("rx_valid_count", 32'(pulses), 32'(1));
    chk("rx_data", 32'(got), 32'(d & 9'((1 << nb_c[s]) - 1)));
    chk("rx_parity_err", 32'(pe), 32'(exp_pe));
    chk("rx_frame_err", 32'(fe), 32'(!stop_val));
    chk("rx_perr_hold", 32'(perr_v[s]), 32'(exp_pe));
    chk("rx_busy_after", 32'(busy_v[s]), 32'(0));
  endtask

  initial begin
    int pulses, busy_hi, bad;
    logic [8:0] got;
    logic fe;

    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("reset_outputs", 32'({tx_v[s], act_v[s], dtx_v[s], rxv_v[s], perr_v[s], ferr_v[s], busy_v[s]}), 32'(7'b1000000));
      chk("reset_rx_data", 32'(rxd_sel(s)), 32'(0));
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    tx_frame(0, 9'h0A5, 1'b0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      tx_frame(0, 9'($urandom), 1'b0);
      repeat (2) @(negedge clk);
    end

    rx_frame(1, 9'h03C, 1'b0, 1'b1);
    rx_frame(1, 9'h03C, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      rx_frame(1, 9'($urandom), 1'($urandom), 1'($urandom));

    tx_frame(2, 9'h041, 1'b1);
    tx_frame(2, 9'($urandom), 1'b0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      rx_frame(2, 9'($urandom), 1'($urandom), 1'($urandom));

    // Let the 8N1 receiver finish anything it picked up from the other formats.
    repeat (150) @(negedge clk);
    pulses = 0; busy_hi = 0;
    for (int c = 0; c < 40; c++) begin
      rx = (c < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (rxv_v[0] === 1'b1) pulses++;
      if (busy_v[0] === 1'b1) busy_hi++;
    end
    chk("glitch_no_valid", 32'(pulses), 32'(0));
    chk("glitch_busy_short", 32'(busy_hi >= 1 && busy_hi <= 6), 32'(1));

    pulses = 0; got = '1; fe = 1'b0;
    for (int c = 0; c < 300; c++) begin
      rx = 1'b0;
      @(negedge clk);
      if (rxv_v[0] === 1'b1) begin
        pulses++;
        got = rxd_sel(0);
        fe = ferr_v[0];
      end
    end
    chk("break_valid_once", 32'(pulses), 32'(1));
    chk("break_data", 32'(got), 32'(0));
    chk("break_frame_err", 32'(fe), 32'(1));
    chk("break_wait_high", 32'(busy_v[0]), 32'(1));
    rx = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rxv_v[0] === 1'b1) pulses++;
    end
    chk("break_release", 32'(busy_v[0]), 32'(0));
    chk("break_no_second", 32'(pulses), 32'(1));

    repeat (5) @(negedge clk);
    txd = 9'($urandom);
    start_v[0] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      rx = (c < 10) ? 1'b0 : 1'($urandom);
      @(negedge clk);
      start_v[0] = 1'b0;
    end
    chk("pre_rst_tx_active", 32'(act_v[0]), 32'(1));
    chk("pre_rst_rx_busy", 32'(busy_v[0]), 32'(1));
    rst = 1'b1;
    #1;
    chk("midframe_rst_outputs", 32'({tx_v[0], act_v[0], dtx_v[0], rxv_v[0], perr_v[0], ferr_v[0], busy_v[0]}), 32'(7'b1000000));
    chk("midframe_rst_rx_data", 32'(rxd_sel(0)), 32'(0));
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (dtx_v[0] === 1'b1 || rxv_v[0] === 1'b1) pulses++;
    end
    chk("no_pulse_after_abort", 32'(pulses), 32'(0));
    tx_frame(0, 9'($urandom), 1'b0);

`ifdef UART_PARAM_LOOPBACK_EN
    repeat (3) @(negedge clk);
    loopback = 1'b1;
    @(negedge clk);
    txd = 9'h05A;
    start_v[0] = 1'b1;
    pulses = 0; bad = 0; got = '0; fe = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      if (tx_v[0] !== 1'b1) bad++;
      if (rxv_v[0] === 1'b1) begin
        pulses++;
        got = rxd_sel(0);
        fe = perr_v[0] | ferr_v[0];
      end
    end
    chk("loop_tx_pin_high", 32'(bad), 32'(0));
    chk("loop_rx_valid", 32'(pulses), 32'(1));
    chk("loop_rx_data", 32'(got), 32'(9'h05A));
    chk("loop_rx_errors", 32'(fe), 32'(0));
    loopback = 1'b0;
`else
    bad = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_param.md
Name: uart_param

Overview:
Parametrised full-duplex UART core, the next generation of the team's fixed 8N1 uart wrapper.
- Data width, parity mode and stop-bit count are honoured by both directions (5-9 data bits, none/odd/even parity, 1-2 stop bits).
- Adds receive-side status: rx_valid strobe, parity error, framing error and false-start rejection.
- Sits between a host register block and the board-level TX/RX pins.

Parameters:
- clk_freq, 50000000, system clock frequency in Hz
- baud_rate, 19200, line rate in bits/s; CLKS_PER_BIT = clk_freq/baud_rate (integer division, must be >= 4)
- data_bits, 8, payload width, legal range 5-9
- parity_type, 0, 0 = none, 1 = odd, 2 = even
- stop_bits, 1, number of stop bits, 1 or 2

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- rx  input  1  serial receive line (asynchronous to clk)
- tx_data_in  input  data_bits  word to transmit
- start  input  1  transmit request, sampled while TX idle
- tx  output  1  serial transmit line
- tx_active  output  1  high while a TX frame is in progress
- done_tx  output  1  one-cycle pulse at end of TX frame
- rx_data_out  output  data_bits  last received word
- rx_valid  output  1  one-cycle pulse when rx_data_out updates
- rx_parity_err  output  1  parity status of the last frame, valid with rx_valid
- rx_frame_err  output  1  stop bit sampled low, valid with rx_valid
- rx_busy  output  1  high while RX FSM is not IDLE

Behaviour:
- Reset (async assert, sync release): tx = 1; tx_active, done_tx, rx_valid, rx_parity_err, rx_frame_err and rx_busy = 0; rx_data_out = 0; both FSMs in IDLE; all counters 0.
- TX FSM states: IDLE -> START -> DATA -> PARITY (skipped when parity_type = 0) -> STOP -> IDLE.
- Each TX state holds for CLKS_PER_BIT cycles; STOP holds for stop_bits*CLKS_PER_BIT cycles.
- start high in IDLE at edge N:
  - tx_data_in is latched.
  - tx goes 0 and tx_active goes 1 from edge N+1.
  - Data is sent LSB first.
  - Parity bit: odd means the total count of ones in data+parity is odd; even means that count is even.
- At the end of STOP the FSM returns to IDLE, tx_active falls and done_tx is high for that single cycle.
- start is accepted in the done_tx cycle (back-to-back frames with no idle gap).
- start is ignored while tx_active = 1.
- tx_data_in changes after the latch edge have no effect on the current frame.
- RX input passes through a 2-flop synchroniser; RX logic sees rx 2 cycles late.
- RX FSM states: IDLE -> START_CHK -> DATA -> PARITY (if enabled) -> STOP -> IDLE, plus WAIT_HIGH.
- IDLE: a synchronised falling edge (1 -> 0) enters START_CHK; rx_busy = 1.
- START_CHK: the line is sampled after CLKS_PER_BIT/2 cycles.
  - If the sample is 1, it is a false start: return to IDLE with no rx_valid.
  - Otherwise each following bit is sampled at CLKS_PER_BIT intervals (bit centre).
- Data bits are shifted LSB first; the parity bit is compared against the computed parity.
- Only the first stop bit is checked, even when stop_bits = 2.
- At the first stop-bit centre:
  - rx_data_out is loaded and rx_valid pulses 1 cycle.
  - rx_parity_err is updated; it is always 0 when parity_type = 0.
  - rx_frame_err = 1 if the stop sample is 0.
- Return path after the stop-bit centre:
  - Stop sample 1: go to IDLE.
  - Stop sample 0: go to WAIT_HIGH, which holds until the synchronised rx = 1 (so a break condition yields exactly one frame-error strobe), then goes to IDLE.
- rx_busy is low only in IDLE.
- Error flags hold their value until the next rx_valid.
- TX and RX are fully independent; simultaneous activity is legal.
- rst asserted mid-frame: immediate return to reset values.
  - tx is driven 1 at once (a truncated frame on the line is acceptable).
  - No done_tx or rx_valid pulse is generated for the aborted frame.

Optional Feature:
- Macro: UART_PARAM_LOOPBACK_EN
- Defined:
  - Adds input port loopback (1 bit, placed after start).
  - When loopback = 1, the RX path takes the internal TX serial signal instead of the synchroniser output (no synchroniser delay).
  - The tx pin is held at 1 and the rx pin is ignored.
  - loopback is only changed while both FSMs are IDLE; otherwise behaviour is undefined.
- Not defined: port is absent and RX always uses the synchronised rx pin.

Test Plan:
All tests use clk_freq = 1000000 and baud_rate = 100000 (CLKS_PER_BIT = 10).
1. 8N1, start pulse with tx_data_in = 8'hA5 -> tx frame is 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles; tx_active high for 100 cycles; done_tx pulses once on cycle 100.
2. 8E1 on RX, drive frame for 8'h3C with parity bit 0 -> rx_valid pulse, rx_data_out = 8'h3C, rx_parity_err = 0. Repeat with parity bit 1 -> rx_parity_err = 1, data still 8'h3C.
3. 7O2 on TX, tx_data_in = 7'h41 -> parity bit 1, then two stop bits; frame length 11 bits = 110 cycles; then start held high -> second frame begins in the done_tx cycle with no idle gap.
4. RX glitch: rx low for 3 cycles then high -> no rx_valid, rx_busy returns to 0 within 6 cycles of entering START_CHK. RX break: rx held low for 300 cycles -> exactly one rx_valid with rx_frame_err = 1 and rx_data_out = 8'h00; RX stays in WAIT_HIGH until rx returns to 1.
5. rst asserted at cycle 40 of a TX frame and during RX DATA -> tx = 1 and all status outputs 0 immediately; no done_tx or rx_valid; a new frame transmits correctly after release.
6. With UART_PARAM_LOOPBACK_EN and loopback = 1, transmit 8'h5A -> rx_valid with rx_data_out = 8'h5A and no errors; tx pin stays 1 throughout.
